// File: rtl/serial_add_pkg.sv
// Shared constants and state type for the byte-slice add sequencer.
// Optional overflow output is enabled by defining SERADD_OVF_EN.
package serial_add_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int SLICE_DEF = 8;
   localparam int NSLICE    = WIDTH_DEF / SLICE_DEF;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int IDX_W = idx_width(NSLICE);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

endpackage

// File: rtl/serial_add_if.sv
// Operand, slice-adder and result bundle of the add sequencer.
// out_ovf exists only when SERADD_OVF_EN is defined.
interface serial_add_if #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic [SLICE-1:0] slice_a;
   logic [SLICE-1:0] slice_b;
   logic             slice_cin;
   logic [SLICE-1:0] slice_sum;
   logic             slice_cout;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
`ifdef SERADD_OVF_EN
   logic             out_ovf;
`endif

   modport slave (
      input  in_valid, in_a, in_b, in_cin,
      input  slice_sum, slice_cout, out_ready,
      output in_ready, slice_a, slice_b, slice_cin,
      output out_valid, out_sum, out_cout
`ifdef SERADD_OVF_EN
      , output out_ovf
`endif
   );

   modport master (
      output in_valid, in_a, in_b, in_cin,
      output slice_sum, slice_cout, out_ready,
      input  in_ready, slice_a, slice_b, slice_cin,
      input  out_valid, out_sum, out_cout
`ifdef SERADD_OVF_EN
      , input out_ovf
`endif
   );

endinterface

// File: rtl/serial_add_acc.sv
// Byte-lane accumulator: writes one returned slice sum per cycle
// into the lane selected by idx; cleared asynchronously on reset.
module serial_add_acc
   import serial_add_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SLICE = SLICE_DEF,
   parameter int IW    = IDX_W
) (
   input  logic             TClk,
   input  logic             TRst_n,
   input  logic             wr_en,
   input  logic [IW-1:0]    idx,
   input  logic [SLICE-1:0] slice_sum,
   output logic [WIDTH-1:0] out_sum
);

   logic [WIDTH-1:0] acc_q;

   // store the current slice sum into its byte lane
   always_ff @(posedge TClk or negedge TRst_n) begin
      if (!TRst_n) begin
         acc_q <= '0;
      end else if (wr_en) begin
         acc_q[int'(idx)*SLICE +: SLICE] <= slice_sum;
      end
   end

   assign out_sum = acc_q;

endmodule

// File: rtl/serial_add_seq.sv
// Sequencer feeding an external slice adder LSB slice first, chaining
// the carry in a register. SERADD_OVF_EN adds a registered out_ovf.
module serial_add_seq
   import serial_add_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SLICE = SLICE_DEF
) (
   input logic         TClk,
   input logic         TRst_n,
   serial_add_if.slave bus
);

   localparam int NSL = WIDTH / SLICE;
   localparam int IW  = idx_width(NSL);
   localparam logic [IW-1:0] LAST = IW'(NSL - 1);

   state_t           state_q;
   state_t           state_d;
   logic [IW-1:0]    idx_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             cin_q;
   logic             carry_q;
   logic             cout_q;
   logic             in_rdy;
   logic             out_vld;
   logic             run;
   logic             last;
   logic             accept;

   assign run    = (state_q == RUN);
   assign last   = run && (idx_q == LAST);
   assign accept = bus.in_valid && in_rdy;

   // state register
   always_ff @(posedge TClk or negedge TRst_n) begin
      if (!TRst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next state and handshake outputs
   always_comb begin
      state_d = state_q;
      in_rdy  = 1'b0;
      out_vld = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_rdy = 1'b1;
            if (bus.in_valid) state_d = RUN;
         end
         RUN: begin
            if (last) state_d = DONE;
         end
         DONE: begin
            out_vld = 1'b1;
            in_rdy  = bus.out_ready;
            if (bus.out_ready) begin
               state_d = bus.in_valid ? RUN : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // operand latch, slice index and carry chain
   always_ff @(posedge TClk or negedge TRst_n) begin
      if (!TRst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else if (accept) begin
         a_q   <= bus.in_a;
         b_q   <= bus.in_b;
         cin_q <= bus.in_cin;
         idx_q <= '0;
      end else if (run) begin
         carry_q <= bus.slice_cout;
         idx_q   <= last ? '0 : idx_q + 1'b1;
         if (last) cout_q <= bus.slice_cout;
      end
   end

   assign bus.slice_a   = run ? a_q[int'(idx_q)*SLICE +: SLICE] : '0;
   assign bus.slice_b   = run ? b_q[int'(idx_q)*SLICE +: SLICE] : '0;
   assign bus.slice_cin = run && ((idx_q == '0) ? cin_q : carry_q);
   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = out_vld;
   assign bus.out_cout  = cout_q;

   serial_add_acc #(
      .WIDTH (WIDTH),
      .SLICE (SLICE),
      .IW    (IW)
   ) u_acc (
      .TClk      (TClk),
      .TRst_n    (TRst_n),
      .wr_en     (run),
      .idx       (idx_q),
      .slice_sum (bus.slice_sum),
      .out_sum   (bus.out_sum)
   );

`ifdef SERADD_OVF_EN
   logic ovf_q;

   // overflow from MSB operand bits, MSB sum bit and final carry
   always_ff @(posedge TClk or negedge TRst_n) begin
      if (!TRst_n) begin
         ovf_q <= 1'b0;
      end else if (last) begin
         ovf_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1]
                ^ bus.slice_sum[SLICE-1] ^ bus.slice_cout;
      end
   end

   assign bus.out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq with a behavioural slice adder.
// Build with SERADD_OVF_EN defined to also check out_ovf.
module tb_serial_add_seq;

   logic TClk = 1'b0;
   logic TRst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   serial_add_if #(.WIDTH(32), .SLICE(8)) sif ();

   serial_add_seq #(.WIDTH(32), .SLICE(8)) dut (
      .TClk   (TClk),
      .TRst_n (TRst_n),
      .bus    (sif)
   );

   always #5 TClk = ~TClk;

   // external slice adder, purely combinational
   assign {sif.slice_cout, sif.slice_sum} =
      9'(sif.slice_a) + 9'(sif.slice_b) + 9'(sif.slice_cin);

   task automatic tick();
      @(posedge TClk);
      #1;
   endtask

   task automatic test_reset();
      TRst_n = 1'b0;
      #3;
      n_cmp++;
      if ({sif.out_valid, sif.out_cout, sif.out_sum} !== 34'h0) begin
         n_bad++;
         $display("FAIL reset_out: got %h want 0",
                  {sif.out_valid, sif.out_cout, sif.out_sum});
      end
      n_cmp++;
      if ({sif.slice_a, sif.slice_b, sif.slice_cin} !== 17'h0) begin
         n_bad++;
         $display("FAIL reset_slice: got %h want 0",
                  {sif.slice_a, sif.slice_b, sif.slice_cin});
      end
      tick();
      tick();
      TRst_n = 1'b1;
      tick();
      n_cmp++;
      if (sif.in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_ready: got %b want 1", sif.in_ready);
      end
   endtask

   task automatic test_basic();
      sif.in_a = 32'h12345678;
      sif.in_b = 32'h11111111;
      sif.in_cin = 1'b0;
      sif.in_valid = 1'b1;
      tick();
      sif.in_valid = 1'b0;
      n_cmp++;
      if ({sif.in_ready, sif.slice_a, sif.slice_b} !== 17'h07811) begin
         n_bad++;
         $display("FAIL basic_run: got %h want 07811",
                  {sif.in_ready, sif.slice_a, sif.slice_b});
      end
      repeat (3) tick();
      n_cmp++;
      if (sif.out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_early: got %b want 0", sif.out_valid);
      end
      tick();
      n_cmp++;
      if ({sif.out_valid, sif.out_cout, sif.out_sum} !==
          {2'b10, 32'h23456789}) begin
         n_bad++;
         $display("FAIL basic_sum: got %h want %h",
                  {sif.out_valid, sif.out_cout, sif.out_sum},
                  {2'b10, 32'h23456789});
      end
      sif.out_ready = 1'b1;
      tick();
      sif.out_ready = 1'b0;
      n_cmp++;
      if ({sif.out_valid, sif.in_ready} !== 2'b01) begin
         n_bad++;
         $display("FAIL basic_idle: got %b want 01",
                  {sif.out_valid, sif.in_ready});
      end
   endtask

   task automatic test_ripple();
      sif.in_a = 32'hFFFFFFFF;
      sif.in_b = 32'h00000001;
      sif.in_cin = 1'b0;
      sif.in_valid = 1'b1;
      tick();
      sif.in_valid = 1'b0;
      n_cmp++;
      if (sif.slice_cin !== 1'b0) begin
         n_bad++;
         $display("FAIL ripple_cin0: got %b want 0", sif.slice_cin);
      end
      for (int i = 1; i < 4; i++) begin
         tick();
         n_cmp++;
         if ({sif.slice_cin, sif.slice_a} !== 9'h1FF) begin
            n_bad++;
            $display("FAIL ripple_cin%0d: got %h want 1ff",
                     i, {sif.slice_cin, sif.slice_a});
         end
      end
      tick();
      n_cmp++;
      if ({sif.out_valid, sif.out_cout, sif.out_sum} !==
          {2'b11, 32'h00000000}) begin
         n_bad++;
         $display("FAIL ripple_sum: got %h want %h",
                  {sif.out_valid, sif.out_cout, sif.out_sum},
                  {2'b11, 32'h0});
      end
      sif.out_ready = 1'b1;
      tick();
      sif.out_ready = 1'b0;
   endtask

   task automatic test_cin();
      sif.in_a = 32'h0000FF00;
      sif.in_b = 32'h00000100;
      sif.in_cin = 1'b1;
      sif.in_valid = 1'b1;
      tick();
      sif.in_valid = 1'b0;
      repeat (4) tick();
      n_cmp++;
      if ({sif.out_valid, sif.out_cout, sif.out_sum} !==
          {2'b10, 32'h00010001}) begin
         n_bad++;
         $display("FAIL cin_sum: got %h want %h",
                  {sif.out_valid, sif.out_cout, sif.out_sum},
                  {2'b10, 32'h00010001});
      end
`ifdef SERADD_OVF_EN
      n_cmp++;
      if (sif.out_ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL cin_ovf: got %b want 0", sif.out_ovf);
      end
`endif
      sif.out_ready = 1'b1;
      tick();
      sif.out_ready = 1'b0;
`ifdef SERADD_OVF_EN
      sif.in_a = 32'h7FFFFFFF;
      sif.in_b = 32'h00000001;
      sif.in_cin = 1'b0;
      sif.in_valid = 1'b1;
      tick();
      sif.in_valid = 1'b0;
      repeat (4) tick();
      n_cmp++;
      if ({sif.out_ovf, sif.out_sum} !== {1'b1, 32'h80000000}) begin
         n_bad++;
         $display("FAIL ovf_set: got %h want %h",
                  {sif.out_ovf, sif.out_sum}, {1'b1, 32'h80000000});
      end
      sif.out_ready = 1'b1;
      tick();
      sif.out_ready = 1'b0;
`endif
   endtask

   task automatic test_backpressure();
      sif.in_a = 32'h00000005;
      sif.in_b = 32'h00000003;
      sif.in_cin = 1'b0;
      sif.in_valid = 1'b1;
      tick();
      sif.in_a = 32'h89ABCDEF;
      sif.in_b = 32'h76543210;
      repeat (4) tick();
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if ({sif.out_valid, sif.in_ready, sif.out_sum} !==
             {2'b10, 32'h00000008}) begin
            n_bad++;
            $display("FAIL bp_hold%0d: got %h want %h", i,
                     {sif.out_valid, sif.in_ready, sif.out_sum},
                     {2'b10, 32'h8});
         end
         tick();
      end
      sif.out_ready = 1'b1;
      #1;
      n_cmp++;
      if (sif.in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL bp_ready: got %b want 1", sif.in_ready);
      end
      tick();
      sif.in_valid = 1'b0;
      sif.out_ready = 1'b0;
      n_cmp++;
      if ({sif.out_valid, sif.in_ready} !== 2'b00) begin
         n_bad++;
         $display("FAIL bp_accept: got %b want 00",
                  {sif.out_valid, sif.in_ready});
      end
      repeat (4) tick();
      n_cmp++;
      if ({sif.out_valid, sif.out_cout, sif.out_sum} !==
          {2'b10, 32'hFFFFFFFF}) begin
         n_bad++;
         $display("FAIL bp_second: got %h want %h",
                  {sif.out_valid, sif.out_cout, sif.out_sum},
                  {2'b10, 32'hFFFFFFFF});
      end
      sif.out_ready = 1'b1;
      tick();
      sif.out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit seen;
      sif.in_a = 32'h01010101;
      sif.in_b = 32'h02020202;
      sif.in_cin = 1'b0;
      sif.in_valid = 1'b1;
      tick();
      sif.in_valid = 1'b0;
      tick();
      tick();
      #2;
      TRst_n = 1'b0;
      #1;
      n_cmp++;
      if ({sif.out_valid, sif.out_cout, sif.out_sum} !== 34'h0) begin
         n_bad++;
         $display("FAIL mid_clear: got %h want 0",
                  {sif.out_valid, sif.out_cout, sif.out_sum});
      end
      n_cmp++;
      if ({sif.in_ready, sif.slice_a, sif.slice_cin} !== 10'h200) begin
         n_bad++;
         $display("FAIL mid_idle: got %h want 200",
                  {sif.in_ready, sif.slice_a, sif.slice_cin});
      end
      tick();
      TRst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (sif.out_valid) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_novalid: got %b want 0", seen);
      end
      sif.in_a = 32'h0F0F0F0F;
      sif.in_b = 32'h01010101;
      sif.in_valid = 1'b1;
      tick();
      sif.in_valid = 1'b0;
      repeat (4) tick();
      n_cmp++;
      if ({sif.out_valid, sif.out_cout, sif.out_sum} !==
          {2'b10, 32'h10101010}) begin
         n_bad++;
         $display("FAIL mid_after: got %h want %h",
                  {sif.out_valid, sif.out_cout, sif.out_sum},
                  {2'b10, 32'h10101010});
      end
      sif.out_ready = 1'b1;
      tick();
      sif.out_ready = 1'b0;
   endtask

   task automatic test_stream();
      logic [31:0] va [10];
      logic [31:0] vb [10];
      logic        vc [10];
      logic [32:0] exp_r;
      for (int i = 0; i < 10; i++) begin
         va[i] = $urandom;
         vb[i] = $urandom;
         vc[i] = 1'($urandom_range(1, 0));
      end
      va[3] = 32'hFFFFFFFF;
      vb[3] = 32'hFFFFFFFF;
      vc[3] = 1'b1;
      sif.in_a = va[0];
      sif.in_b = vb[0];
      sif.in_cin = vc[0];
      sif.in_valid = 1'b1;
      sif.out_ready = 1'b1;
      tick();
      for (int k = 0; k < 10; k++) begin
         exp_r = {1'b0, va[k]} + {1'b0, vb[k]} + {32'h0, vc[k]};
         if (k < 9) begin
            sif.in_a = va[k+1];
            sif.in_b = vb[k+1];
            sif.in_cin = vc[k+1];
         end else begin
            sif.in_valid = 1'b0;
         end
         repeat (3) tick();
         n_cmp++;
         if (sif.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_early%0d: got %b want 0",
                     k, sif.out_valid);
         end
         tick();
         n_cmp++;
         if ({sif.out_valid, sif.out_cout, sif.out_sum} !==
             {1'b1, exp_r}) begin
            n_bad++;
            $display("FAIL stream%0d: got %h want %h", k,
                     {sif.out_valid, sif.out_cout, sif.out_sum},
                     {1'b1, exp_r});
         end
         tick();
      end
      sif.out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      sif.in_valid = 1'b0;
      sif.in_a = '0;
      sif.in_b = '0;
      sif.in_cin = 1'b0;
      sif.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_ripple();
      test_cin();
      test_backpressure();
      test_reset_mid();
      test_stream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
